// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/RUN/HALT sequencer that drives the instruction-memory address and registers the fetched word for decode.
// Optional FETCH_PERF_COUNT_EN adds a saturating 16-bit retired-instruction counter (retire_cnt).
module fetch_unit #(
    parameter int                   PC_W       = 8,
    parameter int                   INSTR_W    = 9,
    parameter logic [INSTR_W-1:0]   NOP_INSTR  = 9'b101100100,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = 9'b111111111
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [PC_W-1:0]     start_addr,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [PC_W-1:0]     br_target,
    output logic [PC_W-1:0]     imem_pc,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_W-1:0]     instr_pc,
    output logic                instr_valid,
    output logic                halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]         retire_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [PC_W-1:0]     r_instr_pc;
    logic                r_valid;
    logic                r_halted;

    logic                w_fetch;
    logic                w_is_halt;
    logic                w_start_accept;
    logic [PC_W-1:0]     w_pc_inc;

    // A fetch commits only in RUN when the branch bubble and the stall hold both stay out of the way.
    assign w_fetch        = (r_state == S_RUN) && !br_taken && !stall;
    assign w_is_halt      = (imem_data == HALT_INSTR);
    assign w_start_accept = start && ((r_state == S_IDLE) || (r_state == S_HALT));
    assign w_pc_inc       = r_pc + PC_W'(1);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values; reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_pc    <= start_addr;
                    end
                end
                S_RUN: begin
                    if (br_taken) begin
                        r_pc    <= br_target;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr    <= imem_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state  <= S_RUN;
                        r_pc     <= start_addr;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_pc     <= '0;
                    r_instr  <= NOP_INSTR;
                    r_valid  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign imem_pc     = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] r_retire_cnt;

    // Every committed fetch retires one instruction, the halt word included; bubbles do not count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_start_accept) begin
            r_retire_cnt <= '0;
        end else if (w_fetch && (r_retire_cnt != 16'hFFFF)) begin
            r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized traffic against a behavioural model of the fetch rules.
// Builds with or without FETCH_PERF_COUNT_EN; the retire counter is checked only when the macro is defined.
module tb_fetch_unit;

    localparam logic [8:0] NOP  = 9'b101100100;
    localparam logic [8:0] HALT = 9'b111111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic        stall;
    logic        br_taken;
    logic [7:0]  br_target;
    logic [7:0]  imem_pc;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] retire_cnt;
`endif

    logic [8:0]  mem [256];

    int total = 0;
    int bad   = 0;

    typedef enum int { M_IDLE, M_RUN, M_HALT } mode_e;
    mode_e       m_mode;
    logic [7:0]  m_pc;
    logic [8:0]  m_instr;
    logic [7:0]  m_instr_pc;
    logic        m_valid;
    int          m_retired;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_pc];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_pc     (imem_pc),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .retire_cnt  (retire_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: apply the fetch rules for the inputs present at the coming edge.
    task automatic model_edge();
        logic [8:0] word;
        if (!rst_n) begin
            m_mode = M_IDLE; m_pc = 8'h00; m_instr = NOP; m_instr_pc = 8'h00;
            m_valid = 1'b0; m_retired = 0;
        end else if (m_mode == M_IDLE) begin
            if (start) begin
                m_mode = M_RUN; m_pc = start_addr; m_retired = 0;
            end
        end else if (m_mode == M_RUN) begin
            if (br_taken) begin
                m_pc = br_target; m_instr = NOP; m_valid = 1'b0;
            end else if (!stall) begin
                word       = mem[m_pc];
                m_instr    = word;
                m_instr_pc = m_pc;
                m_valid    = 1'b1;
                if (m_retired < 65535) m_retired = m_retired + 1;
                if (word == HALT) m_mode = M_HALT;
                else m_pc = 8'((int'(m_pc) + 1) % 256);
            end
        end else begin
            m_valid = 1'b0;
            if (start) begin
                m_mode = M_RUN; m_pc = start_addr; m_retired = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_pc", 32'(imem_pc), 32'(m_pc));
        check("instr", 32'(instr), 32'(m_instr));
        check("instr_pc", 32'(instr_pc), 32'(m_instr_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_mode == M_HALT));
`ifdef FETCH_PERF_COUNT_EN
        check("retire_cnt", 32'(retire_cnt), 32'(m_retired));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, 8'(i)};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; stall = 1'b0;
        br_taken = 1'b0; br_target = 8'h00;
        fill_linear();

        // Reset state
        step();
        step();
        check("rst_instr_nop", 32'(instr), 32'(NOP));
        check("rst_valid", 32'(instr_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_pc0", 32'(imem_pc), 32'h00);

        // Start at 0x10, sequential fetch
        start = 1'b1; start_addr = 8'h10;
        step();
        start = 1'b0;
        check("start_pc", 32'(imem_pc), 32'h10);
        check("start_valid0", 32'(instr_valid), 32'd0);
        step();
        check("seq_pc10", 32'(instr_pc), 32'h10);
        check("seq_v10", 32'(instr_valid), 32'd1);
        check("seq_i10", 32'(instr), 32'h010);
        step();
        check("seq_pc11", 32'(instr_pc), 32'h11);
        step();
        check("seq_pc12", 32'(instr_pc), 32'h12);

        // PC wrap from 0xFF to 0x00
        rst_n = 1'b0; step(); rst_n = 1'b1;
        start = 1'b1; start_addr = 8'hFE; step(); start = 1'b0;
        step();
        step();
        check("wrap_ipc_ff", 32'(instr_pc), 32'hFF);
        check("wrap_pc_00", 32'(imem_pc), 32'h00);
        step();
        check("wrap_ipc_00", 32'(instr_pc), 32'h00);

        // Stall for three cycles with PC at 0x05
        br_taken = 1'b1; br_target = 8'h04; step(); br_taken = 1'b0;
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc", 32'(imem_pc), 32'h05);
            check("stall_ipc", 32'(instr_pc), 32'h04);
            check("stall_instr", 32'(instr), 32'h004);
        end
        stall = 1'b0;
        step();
        check("unstall_ipc", 32'(instr_pc), 32'h05);
        check("unstall_valid", 32'(instr_valid), 32'd1);

        // Branch together with stall: branch wins
        br_taken = 1'b1; br_target = 8'h40; stall = 1'b1;
        step();
        br_taken = 1'b0; stall = 1'b0;
        check("br_nop", 32'(instr), 32'(NOP));
        check("br_valid0", 32'(instr_valid), 32'd0);
        check("br_pc40", 32'(imem_pc), 32'h40);
        step();
        check("br_ipc40", 32'(instr_pc), 32'h40);
        check("br_v40", 32'(instr_valid), 32'd1);

        // Branch to the current PC: one bubble then refetch
        br_taken = 1'b1; br_target = 8'h41; step(); br_taken = 1'b0;
        check("self_br_valid0", 32'(instr_valid), 32'd0);
        step();
        check("self_br_ipc", 32'(instr_pc), 32'h41);

        // start while running is ignored
        start = 1'b1; start_addr = 8'h80; step(); start = 1'b0;
        check("run_start_ign", 32'(imem_pc), 32'h43);

        // Halt at 0x22, then restart from 0
        mem[8'h22] = HALT;
        br_taken = 1'b1; br_target = 8'h20; step(); br_taken = 1'b0;
        step(); step(); step();
        check("halt_ipc", 32'(instr_pc), 32'h22);
        check("halt_instr", 32'(instr), 32'(HALT));
        check("halt_valid1", 32'(instr_valid), 32'd1);
        step();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_valid0", 32'(instr_valid), 32'd0);
        check("halt_pc", 32'(imem_pc), 32'h22);
        br_taken = 1'b1; br_target = 8'h99; stall = 1'b1; step();
        br_taken = 1'b0; stall = 1'b0;
        check("halt_br_ign", 32'(imem_pc), 32'h22);
        start = 1'b1; start_addr = 8'h00; step(); start = 1'b0;
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_pc", 32'(imem_pc), 32'h00);
        step();
        check("restart_ipc", 32'(instr_pc), 32'h00);
        mem[8'h22] = 9'h022;

        // Five fetches, one bubble, halt; then reset mid-run
        rst_n = 1'b0; step(); rst_n = 1'b1;
        mem[8'h50] = HALT;
        start = 1'b1; start_addr = 8'h30; step(); start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        br_taken = 1'b1; br_target = 8'h50; step(); br_taken = 1'b0;
        step();
        step();
        check("perf_halted", 32'(halted), 32'd1);
`ifdef FETCH_PERF_COUNT_EN
        check("perf_cnt6", 32'(retire_cnt), 32'd6);
`endif
        start = 1'b1; start_addr = 8'h10; step(); start = 1'b0;
`ifdef FETCH_PERF_COUNT_EN
        check("perf_clear", 32'(retire_cnt), 32'd0);
`endif
        step(); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("midrst_pc", 32'(imem_pc), 32'h00);
        check("midrst_instr", 32'(instr), 32'(NOP));
        check("midrst_valid", 32'(instr_valid), 32'd0);
        mem[8'h50] = 9'h050;

        // Randomized traffic
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(15, 0) == 0) ? HALT : 9'($urandom);
        for (int n = 0; n < 3000; n++) begin
            rst_n      = ($urandom_range(199, 0) != 0);
            start      = ($urandom_range(9, 0) == 0);
            start_addr = 8'($urandom);
            stall      = ($urandom_range(3, 0) == 0);
            br_taken   = ($urandom_range(9, 0) == 0);
            br_target  = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
